// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit adder that processes CHUNK bits
// per clock, least-significant chunk first, carrying between cycles in a
// register. Request/response via valid/ready on both sides.
// Optional feature macro: SIGNED_OVERFLOW_EN adds a registered 'overflow'
// output flagging two's-complement overflow of the full-width sum.
//
//   state | meaning
//   IDLE  | waiting for an operation, in_ready high
//   BUSY  | adding one chunk per cycle from the latched operands
//   DONE  | result held on toplam/carry_out until out_ready
module chunked_serial_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sayi1,
  input  logic [WIDTH-1:0] sayi2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] toplam,
  output logic             carry_out,
`ifdef SIGNED_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK:0]   sum_c;
  logic             last;

  assign last = (cnt == CW'(NUM_CHUNKS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = BUSY;
      BUSY:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state flops.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Select the current chunk of each latched operand with constant part-selects.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt == CW'(k)) begin
        ca = a_q[k*CHUNK +: CHUNK];
        cb = b_q[k*CHUNK +: CHUNK];
      end
    end
    sum_c = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
  end

  // Operand latch, chunk counter, carry register and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      toplam    <= '0;
      carry_out <= 1'b0;
`ifdef SIGNED_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= sayi1;
            b_q     <= sayi2;
            carry_q <= carry_in;
            cnt     <= '0;
            toplam  <= '0;
`ifdef SIGNED_OVERFLOW_EN
            overflow <= 1'b0;
`endif
          end
        end
        BUSY: begin
          for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (cnt == CW'(k)) toplam[k*CHUNK +: CHUNK] <= sum_c[CHUNK-1:0];
          end
          carry_q <= sum_c[CHUNK];
          cnt     <= last ? '0 : cnt + CW'(1);
          if (last) begin
            carry_out <= sum_c[CHUNK];
`ifdef SIGNED_OVERFLOW_EN
            // The top chunk's MSB is the sign bit of the full sum.
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sum_c[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder at WIDTH=64, CHUNK=8.
module tb_chunked_serial_adder;

  localparam int WIDTH = 64;
  localparam int CHUNK = 8;
  localparam int NUM_CHUNKS = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] sayi1 = '0;
  logic [WIDTH-1:0] sayi2 = '0;
  logic             carry_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] toplam;
  logic             carry_out;
  logic             busy;
`ifdef SIGNED_OVERFLOW_EN
  logic             overflow;
`endif

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sayi1(sayi1), .sayi2(sayi2), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .toplam(toplam), .carry_out(carry_out),
`ifdef SIGNED_OVERFLOW_EN
    .overflow(overflow),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model of the operation in flight: plain full-width arithmetic.
  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin);
    logic [WIDTH:0] full;
    full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    exp_sum  = full[WIDTH-1:0];
    exp_cout = full[WIDTH];
    exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
  endtask

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("model_toplam", {1'b0, toplam}, {1'b0, exp_sum});
      chk("model_cout", {64'd0, carry_out}, {64'd0, exp_cout});
      chk("done_in_ready", {64'd0, in_ready}, 65'd0);
      chk("done_busy", {64'd0, busy}, 65'd1);
`ifdef SIGNED_OVERFLOW_EN
      chk("model_ovf", {64'd0, overflow}, {64'd0, exp_ovf});
`endif
    end
  end

  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {64'd0, in_ready}, 65'd1);
    sayi1 = a; sayi2 = b; carry_in = cin; in_valid = 1'b1;
    set_model(a, b, cin);
    @(posedge clk);
    #1 in_valid = 1'b0;
    sayi1 = $urandom(); sayi2 = $urandom(); carry_in = 1'b0;
  endtask

  // One full operation: latency check, optional literal pins, backpressure.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int hold, input bit lit,
                        input logic [WIDTH-1:0] lit_sum, input logic lit_cout,
                        input logic lit_ovf);
    int lat;
    accept(a, b, cin);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 65'(lat), 65'(NUM_CHUNKS));
    if (lit) begin
      chk("lit_toplam", {1'b0, toplam}, {1'b0, lit_sum});
      chk("lit_cout", {64'd0, carry_out}, {64'd0, lit_cout});
`ifdef SIGNED_OVERFLOW_EN
      chk("lit_ovf", {64'd0, overflow}, {64'd0, lit_ovf});
`else
      if (lit_ovf === 1'bx) chk("lit_ovf_arg", 65'd0, 65'd1);
`endif
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      sayi1 = {$urandom(), $urandom()};
      sayi2 = {$urandom(), $urandom()};
      carry_in = ~carry_in;
      @(posedge clk);
      #1;
      chk("hold_valid", {64'd0, out_valid}, 65'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("release_valid", {64'd0, out_valid}, 65'd0);
    chk("release_ready", {64'd0, in_ready}, 65'd1);
    chk("release_busy", {64'd0, busy}, 65'd0);
  endtask

  initial begin
    int seen;
    // Reset held from time 0.
    #12;
    chk("rst_in_ready", {64'd0, in_ready}, 65'd1);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_toplam", {1'b0, toplam}, 65'd0);
    chk("rst_cout", {64'd0, carry_out}, 65'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b1, 64'h0, 1'b1, 1'b0);
    run_op(64'h0, 64'h0, 1'b1, 0, 1'b1, 64'h1, 1'b0, 1'b0);
    run_op(64'h00FF, 64'h0001, 1'b0, 0, 1'b1, 64'h0100, 1'b0, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5, 1'b1,
           64'h2222_2222_2222_2212, 1'b0, 1'b0);

    // Abort mid-operation: reset asserted between edges while on chunk 3.
    accept(64'hDEAD_BEEF_0000_1111, 64'h1111_2222_3333_4444, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_in_ready", {64'd0, in_ready}, 65'd1);
    chk("abort_out_valid", {64'd0, out_valid}, 65'd0);
    chk("abort_busy", {64'd0, busy}, 65'd0);
    chk("abort_toplam", {1'b0, toplam}, 65'd0);
    chk("abort_cout", {64'd0, carry_out}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 65'(seen), 65'd0);
    run_op(64'h10, 64'h20, 1'b0, 0, 1'b1, 64'h30, 1'b0, 1'b0);

    // Signed-overflow corner cases (overflow checked only when built in).
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b1,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2, 1'b1,
           64'h0, 1'b1, 1'b1);
    run_op(64'h5, 64'h3, 1'b0, 0, 1'b1, 64'h8, 1'b0, 1'b0);

    // Random operands against the model only.
    for (int i = 0; i < 6; i++)
      run_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
             i % 3, 1'b0, 64'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
